// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO_DEPTH-entry byte queue feeding a
// fixed-divider serializer with a registered line output.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLK_DIV    = 1250,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       hw_clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       wr_full,
    output logic       wr_drop,
    output logic [4:0] fifo_level,
    output logic       busy,
    output logic       uarttx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [4:0] LVL_FULL = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [4:0]      level_nx;
    logic            push;
    logic            pop;
    logic            bit_end;

    // Full is the registered flag, so a pop on the same edge never frees a slot.
    assign push    = wr_en && !wr_full;
    assign pop     = (state == IDLE) && (fifo_level != 5'd0);
    assign bit_end = (baud_cnt == DIV_LAST);

    always_comb begin
        level_nx = fifo_level;
        if (push && !pop)
            level_nx = fifo_level + 5'd1;
        else if (pop && !push)
            level_nx = fifo_level - 5'd1;
    end

    always_ff @(posedge hw_clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= 5'd0;
            wr_full    <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            wr_drop    <= wr_en && wr_full;
            fifo_level <= level_nx;
            wr_full    <= (level_nx == LVL_FULL);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            uarttx   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    uarttx <= 1'b1;
                    busy   <= 1'b0;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= 16'd0;
                        state    <= START;
                        uarttx   <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        uarttx   <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            state  <= STOP;
                            uarttx <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            uarttx  <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes, a line-decoding receiver
// that checks frames against a queue of expected bytes.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_full;
    logic       wr_drop;
    logic [4:0] fifo_level;
    logic       busy;
    logic       uarttx;

    logic       wr_en_b = 1'b0;
    logic [7:0] wr_data_b = 8'd0;
    logic       wr_full_b;
    logic       wr_drop_b;
    logic [4:0] fifo_level_b;
    logic       busy_b;
    logic       uarttx_b;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
        .hw_clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .wr_drop(wr_drop), .fifo_level(fifo_level),
        .busy(busy), .uarttx(uarttx)
    );

    uart_tx_fifo #(.CLK_DIV(1250), .FIFO_DEPTH(8)) dut_b (
        .hw_clk(clk), .resetn(resetn), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .wr_full(wr_full_b), .wr_drop(wr_drop_b), .fifo_level(fifo_level_b),
        .busy(busy_b), .uarttx(uarttx_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Receiver/monitor: decodes frames on uarttx and scores them.
    logic [7:0] expq[$];
    int         starts = 0;
    int         frames = 0;
    int         last_start = 0;
    int         prev_start = 0;
    logic       mon_active = 1'b0;
    logic       mon_prev = 1'b1;
    int         mon_cnt = 0;
    int         pos;
    int         idx;
    logic       bit_val;
    logic       bit_ok;
    logic [9:0] bits;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
        end else if (!mon_active) begin
            if (mon_prev && !uarttx) begin
                mon_active = 1'b1;
                mon_cnt    = 1;
                bit_val    = 1'b0;
                bit_ok     = 1'b1;
                starts++;
                prev_start = last_start;
                last_start = cyc;
            end
            mon_prev = uarttx;
        end else begin
            pos = mon_cnt % DIV;
            idx = mon_cnt / DIV;
            if (pos == 0)
                bit_val = uarttx;
            else if (uarttx != bit_val)
                bit_ok = 1'b0;
            if (pos == DIV - 1)
                bits[idx] = bit_val;
            mon_cnt++;
            if (mon_cnt == 10 * DIV) begin
                mon_active = 1'b0;
                mon_prev   = uarttx;
                check("frame_shape", int'({bits[9], bits[0], bit_ok}), 5);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got 0x%0h, expected no frame",
                             bits[8:1]);
                end else begin
                    exp_b = expq.pop_front();
                    check("frame_data", int'(bits[8:1]), int'(exp_b));
                end
                frames++;
            end
        end
    end

    task automatic drive(input logic [7:0] b, input bit acc);
        wr_en   = 1'b1;
        wr_data = b;
        if (acc)
            expq.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (frames < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("frames_seen", frames, n);
    endtask

    initial begin
        int n;
        int t;
        int drops;
        int st;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        check("rst_tx", int'(uarttx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_full", int'(wr_full), 0);
        check("rst_drop", int'(wr_drop), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_b", int'({uarttx_b, busy_b, wr_full_b, wr_drop_b, fifo_level_b}), 256);

        // Single byte 0x55 from idle.
        drive(8'h55, 1'b1);
        wr_en = 1'b0;
        check("t1_level1", int'(fifo_level), 1);
        check("t1_tx_still_high", int'(uarttx), 1);
        @(negedge clk);
        check("t1_tx_fall", int'(uarttx), 0);
        check("t1_busy", int'(busy), 1);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("t1_busy_len", n, 40);
        wait_frames(1);
        check("t1_level0", int'(fifo_level), 0);

        // Two back-to-back bytes.
        repeat (3) @(negedge clk);
        drive(8'h50, 1'b1);
        check("t2_level_a", int'(fifo_level), 1);
        drive(8'h30, 1'b1);
        wr_en = 1'b0;
        check("t2_level_b", int'(fifo_level), 1);
        wait_frames(3);
        check("t2_start_gap", last_start - prev_start, 41);
        check("t2_level0", int'(fifo_level), 0);

        // Ten pushes: nine fit, the tenth is dropped.
        repeat (3) @(negedge clk);
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            drive(8'(i), i < 9);
            drops += int'(wr_drop);
            if (i == 8) begin
                check("t3_full", int'(wr_full), 1);
                check("t3_level8", int'(fifo_level), 8);
            end
        end
        wr_en = 1'b0;
        check("t3_drop_now", int'(wr_drop), 1);
        check("t3_level_hold", int'(fifo_level), 8);
        @(negedge clk);
        drops += int'(wr_drop);
        check("t3_drop_count", drops, 1);

        // Push while full on the pop edge.
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t4_idle_seen", int'(busy), 0);
        check("t4_pre_level", int'(fifo_level), 8);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        check("t4_drop", int'(wr_drop), 1);
        check("t4_level7", int'(fifo_level), 7);
        check("t4_not_full", int'(wr_full), 0);
        wait_frames(12);

        // Reset during DATA bit 3 of 0xA5 with three bytes queued.
        repeat (3) @(negedge clk);
        drive(8'hA5, 1'b0);
        drive(8'h11, 1'b0);
        drive(8'h22, 1'b0);
        drive(8'h33, 1'b0);
        wr_en = 1'b0;
        check("t5_level3", int'(fifo_level), 3);
        repeat (16) @(negedge clk);
        check("t5_bit3", int'(uarttx), 0);
        check("t5_busy_pre", int'(busy), 1);
        st = starts;
        resetn = 1'b0;
        #1;
        check("t5_rst_tx", int'(uarttx), 1);
        check("t5_rst_level", int'(fifo_level), 0);
        check("t5_rst_busy", int'(busy), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (200) @(negedge clk);
        check("t5_no_frames", starts, st);
        check("t5_tx_idle", int'(uarttx), 1);
        check("t5_level_post", int'(fifo_level), 0);

        // Full-rate divider: 0xFF at CLK_DIV=1250.
        wr_en_b   = 1'b1;
        wr_data_b = 8'hFF;
        @(negedge clk);
        wr_en_b = 1'b0;
        t = 0;
        while (uarttx_b && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("t6_start_seen", int'(uarttx_b), 0);
        n = 0;
        while (!uarttx_b && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("t6_start_len", n, 1250);
        while (busy_b && n < 20000) begin
            n++;
            @(negedge clk);
        end
        check("t6_frame_len", n, 12500);
        check("t6_tx_idle", int'(uarttx_b), 1);

        check("expq_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
